// File: rtl/crossy_robbers_key_ctrl.sv
// rtl/crossy_robbers_key_ctrl.sv - debounced push-button controller with sticky press capture and IRQ
// Optional auto-repeat of press events is built when KEY_CTRL_REPEAT_EN is defined.
module crossy_robbers_key_ctrl #(
  parameter int N_KEYS           = 2,
  parameter int KEY_ACTIVE_LOW   = 1,
  parameter int CNT_W            = 20,
  parameter int DEBOUNCE_DEFAULT = 500000,
  parameter int REPEAT_DELAY     = 25000000,
  parameter int REPEAT_PERIOD    = 5000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [N_KEYS-1:0] in_port,
  output logic              irq,
  output logic [N_KEYS-1:0] key_level
);

  typedef enum logic {ST_STABLE, ST_COUNT} db_state_t;

  localparam logic [N_KEYS-1:0] IDLE_RAW = (KEY_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

`ifdef KEY_CTRL_REPEAT_EN
  localparam logic REPEAT_BIT = 1'b1;
`else
  localparam logic REPEAT_BIT = (REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0);
`endif

  logic [N_KEYS-1:0] sync1_q, sync2_q, pressed;
  logic [N_KEYS-1:0] edge_q, edge_d, edge_clr, level_rise, rpt_set;
  logic [N_KEYS-1:0] mask_q;
  logic [CNT_W-1:0]  period_q;
  logic [CNT_W:0]    eff_period;
  logic [31:0]       rd_mux;
  logic              wr_en;
  logic              unused_wdata;

  assign unused_wdata = ^writedata;
  assign wr_en        = chipselect & ~write_n;

  // Two-flop synchroniser, idling at the released raw level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= IDLE_RAW;
      sync2_q <= IDLE_RAW;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  assign pressed    = (KEY_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
  assign eff_period = (period_q == '0) ? (CNT_W+1)'(1) : {1'b0, period_q};

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_key
      db_state_t        state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             level_q, level_d;
      logic [CNT_W:0]   inc;

      // Counting cycle included: a period of P toggles on the P-th differing cycle
      assign inc = ((state_q == ST_STABLE) ? '0 : {1'b0, cnt_q}) + (CNT_W+1)'(1);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state_q <= ST_STABLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          level_q <= level_d;
        end
      end

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (state_q)
          ST_STABLE: begin
            cnt_d = '0;
            if (pressed[gi] != level_q) begin
              if (inc >= eff_period) begin
                level_d = ~level_q;
              end else begin
                state_d = ST_COUNT;
                cnt_d   = inc[CNT_W-1:0];
              end
            end
          end
          ST_COUNT: begin
            if (pressed[gi] == level_q) begin
              state_d = ST_STABLE;
              cnt_d   = '0;
            end else if (inc >= eff_period) begin
              level_d = ~level_q;
              state_d = ST_STABLE;
              cnt_d   = '0;
            end else begin
              cnt_d = inc[CNT_W] ? CNT_MAX : inc[CNT_W-1:0];
            end
          end
        endcase
      end

      assign level_rise[gi] = level_d & ~level_q;
      assign key_level[gi]  = level_q;

`ifdef KEY_CTRL_REPEAT_EN
      logic [31:0] rpt_cnt_q;
      logic        rpt_first_q;
      logic        rpt_hit;

      assign rpt_hit = level_q &&
                       ((rpt_cnt_q + 32'd1) ==
                        (rpt_first_q ? 32'(REPEAT_DELAY) : 32'(REPEAT_PERIOD)));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rpt_cnt_q   <= '0;
          rpt_first_q <= 1'b1;
        end else if (!level_q) begin
          rpt_cnt_q   <= '0;
          rpt_first_q <= 1'b1;
        end else if (rpt_hit) begin
          rpt_cnt_q   <= '0;
          rpt_first_q <= 1'b0;
        end else if (rpt_cnt_q != '1) begin
          rpt_cnt_q <= rpt_cnt_q + 32'd1;
        end
      end

      assign rpt_set[gi] = rpt_hit;
`else
      assign rpt_set[gi] = 1'b0;
`endif
    end
  endgenerate

  // Set has priority over a same-cycle software clear
  assign edge_clr = (wr_en && address == 2'd2) ? writedata[N_KEYS-1:0] : '0;
  assign edge_d   = (edge_q & ~edge_clr) | level_rise | rpt_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_q   <= '0;
      mask_q   <= '0;
      period_q <= CNT_W'(DEBOUNCE_DEFAULT);
      irq      <= 1'b0;
    end else begin
      edge_q <= edge_d;
      irq    <= |(edge_q & mask_q);
      if (wr_en && address == 2'd1) mask_q   <= writedata[N_KEYS-1:0];
      if (wr_en && address == 2'd3) period_q <= writedata[CNT_W-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0: rd_mux[N_KEYS-1:0] = key_level;
      2'd1: begin
        rd_mux[N_KEYS-1:0] = mask_q;
        rd_mux[31]         = REPEAT_BIT;
      end
      2'd2: rd_mux[N_KEYS-1:0] = edge_q;
      2'd3: rd_mux[CNT_W-1:0]  = period_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= chipselect ? rd_mux : '0;
  end

endmodule

// File: tb/tb_crossy_robbers_key_ctrl.sv
// tb/tb_crossy_robbers_key_ctrl.sv - self-checking bench for crossy_robbers_key_ctrl (default build)
module tb_crossy_robbers_key_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [1:0]  in_port = 2'b11;
  logic        irq;
  logic [1:0]  key_level;

  crossy_robbers_key_ctrl dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq), .key_level(key_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       nm;
  } vec_t;
  vec_t tbl[16];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string nm);
    chipselect = 1'b1; address = a;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    tick();
    chipselect = 1'b0;
    check(name_q.pop_front(), readdata, exp_q.pop_front());
  endtask

  // Cycles until key_level[key] reads 1, or -1 if the bound expires
  task automatic wait_rise(input int key, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (key_level[key]) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    logic rose;

    tbl[0]  = '{1'b0, 2'd0, 32'h0, 32'd0,      "rst_data"};
    tbl[1]  = '{1'b0, 2'd1, 32'h0, 32'd0,      "rst_mask"};
    tbl[2]  = '{1'b0, 2'd2, 32'h0, 32'd0,      "rst_edge"};
    tbl[3]  = '{1'b0, 2'd3, 32'h0, 32'd500000, "rst_period"};
    tbl[4]  = '{1'b1, 2'd3, 32'd8, 32'd0,      ""};
    tbl[5]  = '{1'b0, 2'd3, 32'h0, 32'd8,      "period_rw"};
    tbl[6]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'd0, ""};
    tbl[7]  = '{1'b0, 2'd1, 32'h0, 32'h3,      "mask_width_no_repeat_bit"};
    tbl[8]  = '{1'b1, 2'd0, 32'hFF, 32'd0,     ""};
    tbl[9]  = '{1'b0, 2'd0, 32'h0, 32'd0,      "data_read_only"};
    tbl[10] = '{1'b1, 2'd1, 32'h0, 32'd0,      ""};
    tbl[11] = '{1'b0, 2'd1, 32'h0, 32'd0,      "mask_clear"};
    tbl[12] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'd0, ""};
    tbl[13] = '{1'b0, 2'd3, 32'h0, 32'hFFFFF,  "period_width"};
    tbl[14] = '{1'b1, 2'd3, 32'd8, 32'd0,      ""};
    tbl[15] = '{1'b0, 2'd3, 32'h0, 32'd8,      "period_back_to_8"};

    ticks(3);
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_key_level", {30'd0, key_level}, 32'd0);
    reset_n = 1'b1;
    ticks(2);

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].data);
      else           bus_read(tbl[i].addr, tbl[i].exp, tbl[i].nm);
    end

    // Clean press of key0
    in_port[0] = 1'b0;
    wait_rise(0, 20, n);
    check("press_latency", 32'(n), 32'd10);
    bus_read(2'd2, 32'h1, "press_edge");
    bus_read(2'd0, 32'h1, "press_data");
    tick();
    check("cs_low_reads_zero", readdata, 32'd0);
    check("irq_unmasked_off", {31'd0, irq}, 32'd0);

    in_port = 2'b11;
    ticks(12);
    check("release_level", {30'd0, key_level}, 32'd0);
    bus_read(2'd2, 32'h1, "release_not_captured");
    bus_write(2'd2, 32'h0);
    bus_read(2'd2, 32'h1, "edge_write0_noop");
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, 32'h0, "edge_write1_clears");

    // Bounce: 3-cycle segments never reach the 8-cycle period
    rose = 1'b0;
    for (int seg = 0; seg < 10; seg++) begin
      in_port[0] = (seg % 2 == 0) ? 1'b0 : 1'b1;
      for (int c = 0; c < 3; c++) begin
        tick();
        if (key_level[0]) rose = 1'b1;
      end
    end
    check("bounce_no_rise", {31'd0, rose}, 32'd0);
    in_port[0] = 1'b0;
    wait_rise(0, 20, n);
    check("bounce_final_latency", 32'(n), 32'd10);
    bus_read(2'd2, 32'h1, "bounce_one_edge");
    in_port = 2'b11;
    ticks(12);
    bus_write(2'd2, 32'h3);

    // IRQ on key1 only
    bus_write(2'd1, 32'h2);
    in_port = 2'b01;
    wait_rise(1, 20, n);
    check("key1_latency", 32'(n), 32'd10);
    check("irq_lags_edge", {31'd0, irq}, 32'd0);
    tick();
    check("irq_set", {31'd0, irq}, 32'd1);
    bus_write(2'd2, 32'h2);
    tick();
    check("irq_cleared", {31'd0, irq}, 32'd0);
    in_port = 2'b11;
    ticks(12);
    in_port = 2'b10;
    wait_rise(0, 20, n);
    ticks(2);
    check("irq_masked_key0", {31'd0, irq}, 32'd0);
    bus_read(2'd2, 32'h1, "edge_key0_masked");
    in_port = 2'b11;
    ticks(12);
    bus_write(2'd2, 32'h3);

    // Clear write lands on the same edge as the key0 rise
    bus_read(2'd2, 32'h0, "collide_pre_edge");
    in_port = 2'b10;
    ticks(9);
    bus_write(2'd2, 32'h1);
    check("collide_level", {31'd0, key_level[0]}, 32'd1);
    bus_read(2'd2, 32'h1, "collide_set_wins");
    in_port = 2'b11;
    ticks(12);
    bus_write(2'd2, 32'h3);

    // Shrinking PERIOD below a running count toggles on the next cycle
    bus_write(2'd3, 32'd100);
    in_port = 2'b10;
    ticks(30);
    bus_write(2'd3, 32'd5);
    check("shrink_before", {31'd0, key_level[0]}, 32'd0);
    tick();
    check("shrink_toggle", {31'd0, key_level[0]}, 32'd1);
    in_port = 2'b11;
    ticks(10);
    bus_write(2'd2, 32'h3);

    // PERIOD=0 behaves as 1
    bus_write(2'd3, 32'd0);
    in_port = 2'b10;
    wait_rise(0, 20, n);
    check("period0_latency", 32'(n), 32'd3);
    in_port = 2'b11;
    ticks(6);
    bus_write(2'd2, 32'h3);

    // Reset in the middle of a debounce count
    bus_write(2'd3, 32'd8);
    in_port = 2'b01;
    ticks(5);
    reset_n = 1'b0;
    #1;
    check("midrst_key_level", {30'd0, key_level}, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_readdata", readdata, 32'd0);
    in_port = 2'b11;
    ticks(2);
    reset_n = 1'b1;
    tick();
    bus_read(2'd3, 32'd500000, "midrst_period");
    bus_read(2'd2, 32'h0, "midrst_no_edge");
    bus_read(2'd1, 32'h0, "midrst_mask");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
